// File: rtl/kgd_vram_arb.sv
// rtl/kgd_vram_arb.sv - KGD VRAM port-A sequencer: CPU register path with priority over the fill engine
module kgd_vram_arb #(
  parameter int AW         = 14,
  parameter int DW         = 8,
  parameter int VRAM_WORDS = 14300,
  parameter int LW         = 15
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_dat_i,
  output logic [DW-1:0] cpu_dat_o,
  output logic          cpu_ack,
  input  logic          fill_start,
  input  logic [AW-1:0] fill_adr,
  input  logic [LW-1:0] fill_len,
  input  logic [DW-1:0] fill_pat,
  input  logic          fill_abort,
  output logic          fill_busy,
  output logic          fill_done,
  output logic [AW-1:0] vram_adr,
  output logic [DW-1:0] vram_dat,
  output logic          vram_we,
  input  logic [DW-1:0] vram_q
);

  typedef enum logic [2:0] {IDLE, CWR, CRD1, CRD2, CACK, RECOV} state_t;

  localparam logic [AW-1:0] LAST_ADR = AW'(VRAM_WORDS - 1);

  state_t        state;
  logic [AW-1:0] fill_ptr;
  logic [LW-1:0] fill_rem;
  logic [DW-1:0] fill_pat_q;
  logic          fill_slot;

  // A fill byte may use the port only when no CPU access owns it this cycle
  always_comb begin
    fill_slot = 1'b0;
    if (fill_busy && !fill_abort) begin
      fill_slot = ((state == IDLE) && !cpu_req) || (state == RECOV);
    end
  end

  // Port-A sequencer and fill engine; all outputs are registered
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state      <= IDLE;
      cpu_dat_o  <= '0;
      cpu_ack    <= 1'b0;
      fill_busy  <= 1'b0;
      fill_done  <= 1'b0;
      fill_ptr   <= '0;
      fill_rem   <= '0;
      fill_pat_q <= '0;
      vram_adr   <= '0;
      vram_dat   <= '0;
      vram_we    <= 1'b0;
    end else begin
      vram_we   <= 1'b0;
      cpu_ack   <= 1'b0;
      fill_done <= 1'b0;

      case (state)
        IDLE: begin
          if (cpu_req) begin
            vram_adr <= cpu_adr;
            if (cpu_we) begin
              vram_dat <= cpu_dat_i;
              vram_we  <= 1'b1;
              cpu_ack  <= 1'b1;
              state    <= CWR;
            end else begin
              state <= CRD1;
            end
          end
        end
        CWR:   state <= RECOV;
        CRD1:  state <= CRD2;
        CRD2: begin
          // RAM output now reflects the address driven during CRD1
          cpu_dat_o <= vram_q;
          cpu_ack   <= 1'b1;
          state     <= CACK;
        end
        CACK:  state <= RECOV;
        RECOV: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (fill_abort) begin
        fill_busy <= 1'b0;
      end else if (fill_start && !fill_busy) begin
        fill_ptr   <= fill_adr;
        fill_rem   <= fill_len;
        fill_pat_q <= fill_pat;
        fill_busy  <= (fill_len != '0);
        fill_done  <= (fill_len == '0);
      end else if (fill_slot) begin
        vram_adr <= fill_ptr;
        vram_dat <= fill_pat_q;
        vram_we  <= 1'b1;
        fill_ptr <= (fill_ptr == LAST_ADR) ? '0 : fill_ptr + AW'(1);
        fill_rem <= fill_rem - LW'(1);
        if (fill_rem == LW'(1)) begin
          fill_busy <= 1'b0;
          fill_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_kgd_vram_arb.sv
// tb/tb_kgd_vram_arb.sv - scoreboard bench for kgd_vram_arb
module tb_kgd_vram_arb;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n;
  logic        cpu_req, cpu_we;
  logic [13:0] cpu_adr;
  logic [7:0]  cpu_dat_i, cpu_dat_o;
  logic        cpu_ack;
  logic        fill_start, fill_abort, fill_busy, fill_done;
  logic [13:0] fill_adr;
  logic [14:0] fill_len;
  logic [7:0]  fill_pat;
  logic [13:0] vram_adr;
  logic [7:0]  vram_dat, vram_q;
  logic        vram_we;

  int checks = 0;
  int errors = 0;
  int fill_wr_cnt = 0;
  int ack_cnt = 0;
  int done_cnt = 0;

  logic [21:0] exp_cpu[$];
  logic [21:0] exp_fill[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  mem [0:16383];

  kgd_vram_arb dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr),
    .cpu_dat_i(cpu_dat_i), .cpu_dat_o(cpu_dat_o), .cpu_ack(cpu_ack),
    .fill_start(fill_start), .fill_adr(fill_adr), .fill_len(fill_len),
    .fill_pat(fill_pat), .fill_abort(fill_abort), .fill_busy(fill_busy),
    .fill_done(fill_done), .vram_adr(vram_adr), .vram_dat(vram_dat),
    .vram_we(vram_we), .vram_q(vram_q)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // registered-read dual-port RAM, port A only
  always @(posedge wb_clk_i) begin
    if (vram_we) mem[vram_adr] <= vram_dat;
    vram_q <= mem[vram_adr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h expected=none", nm, act);
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a write or a read ack
  always @(negedge wb_clk_i) begin
    logic [21:0] e;
    if (vram_we) begin
      if (cpu_ack) begin
        ack_cnt++;
        if (exp_cpu.size() == 0) unexpected("cpu_wr_unexpected", {vram_adr, vram_dat});
        else begin
          e = exp_cpu.pop_front();
          chk("cpu_wr", {10'd0, vram_adr, vram_dat}, {10'd0, e});
        end
      end else begin
        fill_wr_cnt++;
        if (exp_fill.size() == 0) unexpected("fill_wr_unexpected", {vram_adr, vram_dat});
        else begin
          e = exp_fill.pop_front();
          chk("fill_wr", {10'd0, vram_adr, vram_dat}, {10'd0, e});
        end
      end
    end else if (cpu_ack) begin
      ack_cnt++;
      if (exp_rd.size() == 0) unexpected("rd_ack_unexpected", {24'd0, cpu_dat_o});
      else chk("cpu_rd", {24'd0, cpu_dat_o}, {24'd0, exp_rd.pop_front()});
    end
    if (fill_done) done_cnt++;
  end

  task automatic cpu_access(input logic we, input logic [13:0] adr, input logic [7:0] dat, output int cyc);
    cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_dat_i = dat; cyc = 0;
    do begin @(negedge wb_clk_i); cyc++; end while (!cpu_ack && cyc < 50);
    cpu_req = 1'b0;
    if (!cpu_ack) unexpected("ack_timeout", cyc);
  endtask

  task automatic fill_go(input logic [13:0] adr, input logic [14:0] len, input logic [7:0] pat);
    logic [13:0] a;
    a = adr;
    for (int i = 0; i < int'(len); i++) begin
      exp_fill.push_back({a, pat});
      a = (a == 14'd14299) ? 14'd0 : a + 14'd1;
    end
    fill_start = 1'b1; fill_adr = adr; fill_len = len; fill_pat = pat;
    @(negedge wb_clk_i);
    fill_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    do begin @(negedge wb_clk_i); cyc++; end while (!fill_done && cyc < budget);
    if (!fill_done) unexpected("done_timeout", cyc);
  endtask

  task automatic wait_writes(input int base, input int n);
    int c;
    c = 0;
    while ((fill_wr_cnt - base) < n && c < 500) begin @(negedge wb_clk_i); c++; end
    if ((fill_wr_cnt - base) < n) unexpected("fill_progress_timeout", fill_wr_cnt - base);
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_a"}, {8'd0, cpu_dat_o, cpu_ack, fill_busy, fill_done, vram_we, 12'd0}, 32'd0);
    chk({nm, "_b"}, {10'd0, vram_adr, vram_dat}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, base, dn, ac, d;
    wb_rst_n = 1'b0; cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_dat_i = '0;
    fill_start = 0; fill_abort = 0; fill_adr = '0; fill_len = '0; fill_pat = '0;
    repeat (3) @(negedge wb_clk_i);
    chk_outputs_zero("reset_state");
    wb_rst_n = 1'b1;
    @(negedge wb_clk_i);

    // CPU write, then a second write with req held straight through
    exp_cpu.push_back({14'h0010, 8'hA5});
    cpu_access(1'b1, 14'h0010, 8'hA5, lat);
    chk("wr_latency", lat, 1);
    exp_cpu.push_back({14'h0011, 8'h3C});
    cpu_access(1'b1, 14'h0011, 8'h3C, lat);
    chk("wr_recov_latency", lat, 3);
    repeat (2) @(negedge wb_clk_i);

    // CPU reads back
    exp_rd.push_back(8'hA5);
    cpu_access(1'b0, 14'h0010, 8'h00, lat);
    chk("rd_latency", lat, 3);
    repeat (2) @(negedge wb_clk_i);
    exp_rd.push_back(8'h3C);
    cpu_access(1'b0, 14'h0011, 8'h00, lat);
    chk("rd_latency2", lat, 3);
    @(negedge wb_clk_i);
    chk("rd_data_held", cpu_dat_o, 8'h3C);
    chk("ack_is_pulse", cpu_ack, 0);

    // fill across the wrap point
    base = fill_wr_cnt;
    fill_go(14'd14298, 15'd4, 8'hFF);
    wait_done(20, lat);
    chk("wrap_fill_cycles", lat, 4);
    chk("done_with_last_we", vram_we, 1);
    chk("busy_falls_with_done", fill_busy, 0);
    chk("last_wrap_adr", vram_adr, 14'd1);
    @(negedge wb_clk_i);
    chk("wrap_fill_count", fill_wr_cnt - base, 4);

    // CPU write injected into a long fill
    base = fill_wr_cnt;
    fill_go(14'd100, 15'd100, 8'h33);
    wait_writes(base, 10);
    exp_cpu.push_back({14'h3000, 8'h5A});
    cpu_access(1'b1, 14'h3000, 8'h5A, lat);
    chk("preempt_latency_le2", lat <= 2, 1);
    wait_done(300, lat);
    @(negedge wb_clk_i);
    chk("preempt_fill_count", fill_wr_cnt - base, 100);
    chk("preempt_queue_empty", exp_fill.size(), 0);

    // abort mid-fill
    base = fill_wr_cnt;
    dn = done_cnt;
    fill_go(14'd200, 15'd50, 8'h77);
    wait_writes(base, 5);
    fill_abort = 1'b1;
    @(negedge wb_clk_i);
    fill_abort = 1'b0;
    chk("abort_busy_low", fill_busy, 0);
    repeat (10) @(negedge wb_clk_i);
    d = fill_wr_cnt - base;
    chk("abort_write_count", (d == 5) || (d == 6), 1);
    chk("abort_no_done", done_cnt - dn, 0);
    exp_fill.delete();
    base = fill_wr_cnt;
    fill_go(14'd500, 15'd3, 8'h11);
    wait_done(20, lat);
    chk("after_abort_fill_cycles", lat, 3);
    @(negedge wb_clk_i);
    chk("after_abort_count", fill_wr_cnt - base, 3);

    // reset in the middle of a fill
    base = fill_wr_cnt;
    fill_go(14'd1000, 15'd40, 8'hC3);
    wait_writes(base, 5);
    wb_rst_n = 1'b0;
    @(negedge wb_clk_i);
    chk_outputs_zero("reset_mid_fill");
    exp_fill.delete();
    @(negedge wb_clk_i);
    wb_rst_n = 1'b1;
    base = fill_wr_cnt; dn = done_cnt; ac = ack_cnt;
    repeat (20) @(negedge wb_clk_i);
    chk("post_reset_no_writes", fill_wr_cnt - base, 0);
    chk("post_reset_no_done", done_cnt - dn, 0);

    // reset in the middle of a CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 14'h0010;
    @(negedge wb_clk_i);
    wb_rst_n = 1'b0;
    cpu_req = 1'b0;
    @(negedge wb_clk_i);
    chk_outputs_zero("reset_mid_read");
    @(negedge wb_clk_i);
    wb_rst_n = 1'b1;
    repeat (10) @(negedge wb_clk_i);
    chk("post_reset_no_ack", ack_cnt - ac, 0);

    // zero-length fill
    base = fill_wr_cnt; dn = done_cnt;
    fill_start = 1'b1; fill_adr = 14'd7; fill_len = 15'd0; fill_pat = 8'hEE;
    @(negedge wb_clk_i);
    fill_start = 1'b0;
    chk("len0_done", fill_done, 1);
    chk("len0_busy", fill_busy, 0);
    repeat (5) @(negedge wb_clk_i);
    chk("len0_no_writes", fill_wr_cnt - base, 0);
    chk("len0_one_done", done_cnt - dn, 1);

    chk("cpu_queue_drained", exp_cpu.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kgd_vram_arb.md
Name: kgd_vram_arb

Overview:
- Port-A sequencer and arbiter for the KGD graphics video RAM (8-bit side, registered read data).
- Shares the port between two requesters: the CPU register path (data register reads/writes) and a built-in hardware fill engine (screen clear / pattern fill).
- The CPU always has priority. The fill engine writes one byte per free cycle.
- Sits between the KGD bus-register block and the dual-port VRAM. Port B (video scan) is untouched.

Parameters:
- AW, 14, VRAM byte address width
- DW, 8, VRAM data width
- VRAM_WORDS, 14300, number of valid bytes (400*286/8); fill address wraps at VRAM_WORDS-1 -> 0
- LW, 15, fill length counter width

Ports:
- wb_clk_i  in  1  single clock for the whole block
- wb_rst_n  in  1  reset, synchronous, active-low
- cpu_req  in  1  CPU access request, level; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
- cpu_adr  in  AW  CPU byte address
- cpu_dat_i  in  DW  CPU write data
- cpu_dat_o  out  DW  CPU read data, valid while cpu_ack=1, held until next read
- cpu_ack  out  1  one-cycle completion pulse
- fill_start  in  1  pulse; start fill (ignored while fill_busy)
- fill_adr  in  AW  fill start address
- fill_len  in  LW  number of bytes to fill
- fill_pat  in  DW  fill byte
- fill_abort  in  1  stop fill
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle pulse on normal completion
- vram_adr  out  AW  VRAM port-A address
- vram_dat  out  DW  VRAM port-A write data
- vram_we  out  1  VRAM port-A write enable
- vram_q  in  DW  VRAM port-A read data, 1-cycle registered latency

Behaviour:
- Reset (wb_rst_n=0 at clock edge): all outputs 0, FSM = IDLE, fill counters cleared. A reset during a fill or CPU access aborts it: no further vram_we, no ack, no done.
- FSM states: IDLE, CWR, CRD1, CRD2, CACK, RECOV.
- IDLE:
  - cpu_req=1 and RECOV not active -> latch adr/data; go to CWR if cpu_we else CRD1.
  - Otherwise, if fill_busy, issue one fill write this cycle: vram_adr = fill pointer, vram_dat = fill_pat, vram_we = 1 (registered, appears next cycle).
- CPU write: req sampled at edge N; cycle N+1 is CWR with vram_we=1 and cpu_ack=1; then RECOV.
- CPU read:
  - CRD1 at N+1: vram_adr driven, vram_we=0.
  - CRD2 at N+2: vram_q captured into cpu_dat_o.
  - CACK at N+3: cpu_ack=1.
  - Then RECOV.
- RECOV: one cycle during which cpu_req is ignored, so the requester can drop req. Fill writes may proceed in RECOV. Then return to IDLE.
- CPU priority: a pending cpu_req pre-empts the fill at the next free cycle. A fill write already registered completes first, so worst-case added CPU latency is 1 cycle. While a CPU access is being served, vram_we is driven only for that access.
- Fill engine:
  - fill_start while not busy: latch fill_adr, fill_len, fill_pat; fill_busy=1 next cycle.
  - fill_len = 0: fill_busy stays 0, fill_done pulses next cycle, no writes.
  - Each issued write: pointer+1, with pointer VRAM_WORDS-1 wrapping to 0; remaining count -1.
  - When the last write issues, fill_busy=0 and fill_done=1 in the same cycle as that last vram_we.
  - fill_start while busy is ignored; latched params do not change.
  - fill_abort: no further writes from the next edge; fill_busy=0 next cycle; fill_done not pulsed. Abort wins over a simultaneous fill_start.
  - fill_start and cpu_req in the same cycle: both are accepted; CPU is served first, then the fill begins.
- vram_we is never 1 outside CWR or a fill write cycle.
- vram_adr/vram_dat hold their last value when idle.
- Addresses >= VRAM_WORDS from the CPU are passed through unchanged (the RAM ignores them).

Test Plan:
- Reset release, then CPU write adr=0x0010 data=0xA5 -> vram_we=1 with adr 0x0010, data 0xA5 exactly 1 cycle after req; cpu_ack coincident; next req accepted no earlier than 2 cycles after ack.
- CPU read adr=0x0010 after the above -> cpu_ack 3 cycles after req with cpu_dat_o=0xA5; vram_we stays 0 throughout.
- fill_start adr=14298 len=4 pat=0xFF -> writes to 14298, 14299, 0, 1 on consecutive cycles; fill_done pulses with the 4th write; fill_busy falls with it.
- Fill len=100 with CPU write req injected at fill byte 10 -> at most one more fill write, then the CPU write; fill resumes at the next address with no byte skipped or duplicated; 100 total fill writes.
- fill_abort at byte 5 of len=50 -> exactly 5 or 6 writes, fill_busy=0 next cycle, no fill_done; a subsequent fill_start is accepted.
- wb_rst_n=0 mid-fill and mid-CPU-read -> all outputs 0 on the next edge; no ack or done after reset release; fill_len=0 start -> fill_done pulse, zero writes.
